// File: rtl/pad_scan_pkg.sv
// Shared definitions for the serial gamepad scanner: FSM state encoding and
// the APB register map offsets.
package pad_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SAMPLE,
        ST_CLKHI,
        ST_DONE
    } scan_state_t;

    localparam logic [11:0] OFF_STATE  = 12'h000;
    localparam logic [11:0] OFF_PRESS  = 12'h010;
    localparam logic [11:0] OFF_CTRL   = 12'h020;
    localparam logic [11:0] OFF_FRAMES = 12'h024;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Per-pad registers sit at consecutive word addresses above a bank base.
    function automatic logic [11:0] pad_offset(input logic [11:0] base, input int idx);
        return base + 12'(4 * idx);
    endfunction

endpackage

// File: rtl/pad_shift_chan.sv
// One gamepad channel: serial shift register, debounced-by-frame button state
// and sticky newly-pressed bits with write-one-to-clear.
module pad_shift_chan
    import pad_scan_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift_en,
    input  logic                sample_bit,
    input  logic                clear_shift,
    input  logic                commit,
    input  logic                w1c_en,
    input  logic [NUM_BITS-1:0] w1c_mask,
    output logic [NUM_BITS-1:0] btn_state,
    output logic [NUM_BITS-1:0] press
);

    logic [NUM_BITS-1:0] shift_reg;
    logic [NUM_BITS-1:0] new_press;
    logic [NUM_BITS-1:0] clr_mask;
    logic [NUM_BITS-1:0] press_next;

    // A bit set by the frame commit survives a coincident W1C of that bit.
    always_comb begin
        new_press  = commit ? (shift_reg & ~btn_state) : '0;
        clr_mask   = w1c_en ? w1c_mask : '0;
        press_next = (press & ~clr_mask) | new_press;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            btn_state <= '0;
            press     <= '0;
        end else begin
            if (clear_shift) begin
                shift_reg <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[NUM_BITS-2:0], sample_bit};
            end
            if (commit) begin
                btn_state <= shift_reg;
            end
            press <= press_next;
        end
    end

endmodule

// File: rtl/pad_scan_apb.sv
// APB peripheral that periodically latches and shifts in NUM_PADS serial
// gamepads, exposing button state, sticky presses, a frame counter and an irq.
module pad_scan_apb
    import pad_scan_pkg::*;
#(
    parameter int NUM_PADS = 2,
    parameter int NUM_BITS = 8,
    parameter int DIV      = 150
) (
    input  logic                PCLK,
    input  logic                PRESERN,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [11:0]         PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic                pad_latch,
    output logic                pad_clock,
    input  logic [NUM_PADS-1:0] pad_data,
    output logic                irq
);

    localparam int CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int BIT_W = $clog2(NUM_BITS + 1);

    scan_state_t state;
    scan_state_t state_next;

    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic [BIT_W-1:0]    bit_cnt;
    logic [15:0]         frames;
    logic [1:0]          ctrl;
    logic                en;
    logic                shift_en;
    logic                bit_inc;
    logic                clear_shift;
    logic                commit;
    logic                apb_write;
    logic                apb_read_setup;
    logic [31:0]         rdata;
    logic                any_press;
    logic [NUM_PADS-1:0] w1c_en;
    logic                unused_wdata;

    logic [NUM_BITS-1:0] pad_state [NUM_PADS];
    logic [NUM_BITS-1:0] pad_press [NUM_PADS];

    assign PREADY         = 1'b1;
    assign PSLVERR        = 1'b0;
    assign en             = ctrl[CTRL_EN_BIT];
    assign tick           = (tick_cnt == CNT_W'(DIV));
    assign apb_write      = PSEL & PENABLE & PWRITE;
    assign apb_read_setup = PSEL & ~PENABLE & ~PWRITE;
    assign unused_wdata   = ^PWDATA[31:NUM_BITS];

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_chan
        assign w1c_en[g] = apb_write && (PADDR == pad_offset(OFF_PRESS, g));

        pad_shift_chan #(
            .NUM_BITS(NUM_BITS)
        ) u_chan (
            .clk        (PCLK),
            .rst_n      (PRESERN),
            .shift_en   (shift_en),
            .sample_bit (~pad_data[g]),
            .clear_shift(clear_shift),
            .commit     (commit),
            .w1c_en     (w1c_en[g]),
            .w1c_mask   (PWDATA[NUM_BITS-1:0]),
            .btn_state  (pad_state[g]),
            .press      (pad_press[g])
        );
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        shift_en    = 1'b0;
        bit_inc     = 1'b0;
        clear_shift = 1'b0;
        commit      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick && en) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (tick) begin
                    shift_en   = 1'b1;
                    bit_inc    = 1'b1;
                    state_next = ST_CLKHI;
                end
            end
            ST_CLKHI: begin
                if (tick) begin
                    state_next = (bit_cnt == BIT_W'(NUM_BITS)) ? ST_DONE : ST_SAMPLE;
                end
            end
            ST_DONE: begin
                commit      = 1'b1;
                clear_shift = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Disabling mid-frame abandons the partial frame without committing it.
        if (tick && !en && (state == ST_LATCH || state == ST_SAMPLE || state == ST_CLKHI)) begin
            state_next  = ST_IDLE;
            shift_en    = 1'b0;
            bit_inc     = 1'b0;
            clear_shift = 1'b1;
        end
    end

    // Pad strobes are registered from the next state so they never glitch.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            pad_latch <= 1'b0;
            pad_clock <= 1'b0;
            frames    <= '0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + CNT_W'(1);
            pad_latch <= (state_next == ST_LATCH);
            pad_clock <= (state_next == ST_CLKHI);
            if (clear_shift) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (commit) begin
                frames <= frames + 16'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (PADDR == pad_offset(OFF_STATE, i)) begin
                rdata = 32'(pad_state[i]);
            end
            if (PADDR == pad_offset(OFF_PRESS, i)) begin
                rdata = 32'(pad_press[i]);
            end
        end
        if (PADDR == OFF_CTRL) begin
            rdata = {30'd0, ctrl};
        end
        if (PADDR == OFF_FRAMES) begin
            rdata = {16'd0, frames};
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            ctrl   <= '0;
            PRDATA <= '0;
        end else begin
            if (apb_write && (PADDR == OFF_CTRL)) begin
                ctrl <= PWDATA[1:0];
            end
            if (apb_read_setup) begin
                PRDATA <= rdata;
            end
        end
    end

    always_comb begin
        any_press = 1'b0;
        for (int i = 0; i < NUM_PADS; i++) begin
            any_press = any_press | (|pad_press[i]);
        end
    end

    assign irq = ctrl[CTRL_IRQ_EN_BIT] & any_press;

endmodule

// File: tb/tb_pad_scan_apb.sv
// Directed bench for pad_scan_apb with two pads, 8 bits, DIV=3.
`timescale 1ns/1ps
module tb_pad_scan_apb;

    localparam logic [11:0] A_STATE0 = 12'h000;
    localparam logic [11:0] A_STATE1 = 12'h004;
    localparam logic [11:0] A_PRESS0 = 12'h010;
    localparam logic [11:0] A_PRESS1 = 12'h014;
    localparam logic [11:0] A_CTRL   = 12'h020;
    localparam logic [11:0] A_FRAMES = 12'h024;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        pad_latch;
    logic        pad_clock;
    logic [1:0]  pad_data = 2'b11;
    logic        irq;

    int checks = 0;
    int failures = 0;

    // pat[k] is the level a pad drives for its k-th sample (0 = pressed).
    logic [7:0] pat0 = 8'hFF;
    logic [7:0] pat1 = 8'hFF;
    int         idx = 8;
    logic       latch_d = 1'b0;
    logic       clock_d = 1'b0;
    logic       overlap = 1'b0;

    pad_scan_apb #(
        .NUM_PADS(2),
        .NUM_BITS(8),
        .DIV     (3)
    ) dut (
        .PCLK     (pclk),
        .PRESERN  (presetn),
        .PSEL     (psel),
        .PENABLE  (penable),
        .PWRITE   (pwrite),
        .PADDR    (paddr),
        .PWDATA   (pwdata),
        .PRDATA   (prdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr),
        .pad_latch(pad_latch),
        .pad_clock(pad_clock),
        .pad_data (pad_data),
        .irq      (irq)
    );

    always #5 pclk = ~pclk;

    // Gamepad model: latch falling edge presents bit 0, each clock fall the next bit.
    always @(negedge pclk) begin
        if (latch_d && !pad_latch) idx = 0;
        else if (clock_d && !pad_clock) idx = idx + 1;
        latch_d = pad_latch;
        clock_d = pad_clock;
        pad_data[0] = (idx < 8) ? pat0[idx[2:0]] : 1'b1;
        pad_data[1] = (idx < 8) ? pat1[idx[2:0]] : 1'b1;
        if (pad_latch && pad_clock) overlap = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge pclk);
        penable = 1'b1;
        d = prdata;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_rise_latch(output bit ok);
        logic prev;
        prev = pad_latch;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge pclk);
            if (pad_latch && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = pad_latch;
        end
    endtask

    task automatic wait_clock_rises(input int n, output bit ok);
        logic prev;
        int   seen;
        prev = pad_clock;
        seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge pclk);
            if (pad_clock && !prev) begin
                seen++;
                if (seen == n) begin
                    ok = 1'b1;
                    break;
                end
            end
            prev = pad_clock;
        end
    endtask

    task automatic measure_high(input bit use_clock, output int width);
        width = 1;
        for (int i = 0; i < 32; i++) begin
            @(negedge pclk);
            if ((use_clock ? pad_clock : pad_latch) == 1'b1) width++;
            else break;
        end
    endtask

    // Returns two cycles after the DONE commit of the next complete frame.
    task automatic wait_frame_end(output bit ok);
        bit ok1, ok2;
        wait_rise_latch(ok1);
        wait_clock_rises(8, ok2);
        repeat (6) @(negedge pclk);
        ok = ok1 && ok2;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if ({pad_latch, pad_clock, irq} !== 3'b000 || prdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got latch/clk/irq=%b prdata=%h exp=000 0", {pad_latch, pad_clock, irq}, prdata);
        end
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b0) begin
            failures++;
            $display("FAIL tie_offs got pready=%b pslverr=%b exp 1 0", pready, pslverr);
        end
        presetn = 1'b1;
        apb_read(A_STATE0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_state0 got=%h exp=0", rd); end
        apb_read(A_PRESS0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_press0 got=%h exp=0", rd); end
        apb_read(A_FRAMES, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_frames got=%h exp=0", rd); end
        apb_write(A_CTRL, 32'hFFFF_FFFC);
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL ctrl_unused_bits got=%h exp=0", rd); end
        apb_write(12'h030, 32'hFFFF_FFFF);
        apb_read(12'h030, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", rd); end
        apb_read(12'h008, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL absent_pad_read got=%h exp=0", rd); end
    endtask

    task automatic test_frame;
        logic [31:0] rd;
        bit          ok;
        bit          all_ok;
        int          w;
        int          bad_w;
        longint      t_start, t_end;
        pat0 = 8'h7E;
        pat1 = 8'hFF;
        apb_write(A_CTRL, 32'h1);
        wait_rise_latch(ok);
        t_start = $time;
        measure_high(1'b0, w);
        checks++;
        if (!ok || w != 4) begin failures++; $display("FAIL latch_pulse got found=%0d width=%0d exp 1 4", ok, w); end
        all_ok = 1'b1;
        bad_w = 0;
        for (int k = 0; k < 8; k++) begin
            wait_clock_rises(1, ok);
            if (!ok) all_ok = 1'b0;
            measure_high(1'b1, w);
            if (w != 4) bad_w++;
        end
        t_end = $time;
        checks++;
        if (!all_ok || bad_w != 0) begin failures++; $display("FAIL clock_pulses got all_found=%0d bad_widths=%0d exp 1 0", all_ok, bad_w); end
        checks++;
        if ((t_end - t_start) / 10 != 68) begin
            failures++;
            $display("FAIL frame_span got=%0d cycles exp=68", (t_end - t_start) / 10);
        end
        @(negedge pclk);
        apb_read(A_FRAMES, rd);
        checks++;
        if (rd !== 32'h1) begin failures++; $display("FAIL frames_first got=%h exp=1", rd); end
        apb_read(A_STATE0, rd);
        checks++;
        if (rd !== 32'h81) begin failures++; $display("FAIL state0_first got=%h exp=81", rd); end
        apb_read(A_STATE1, rd);
        checks++;
        if (rd !== 32'h00) begin failures++; $display("FAIL state1_first got=%h exp=0", rd); end
        apb_read(A_PRESS0, rd);
        checks++;
        if (rd !== 32'h81) begin failures++; $display("FAIL press0_first got=%h exp=81", rd); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", irq); end
    endtask

    task automatic test_second_frame;
        logic [31:0] rd;
        bit          ok;
        wait_frame_end(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL second_frame_timeout got=0 exp=1"); end
        apb_read(A_PRESS0, rd);
        checks++;
        if (rd !== 32'h81) begin failures++; $display("FAIL press0_second got=%h exp=81", rd); end
        apb_write(A_PRESS0, 32'h01);
        apb_read(A_PRESS0, rd);
        checks++;
        if (rd !== 32'h80) begin failures++; $display("FAIL press0_w1c got=%h exp=80", rd); end
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        apb_write(A_CTRL, 32'h3);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_enabled got=%b exp=1", irq); end
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_PRESS0; pwdata = 32'hFF;
        @(negedge pclk);
        penable = 1'b1;
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_before_w1c got=%b exp=1", irq); end
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_w1c got=%b exp=0", irq); end
        apb_read(A_PRESS0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL press0_cleared got=%h exp=0", rd); end
    endtask

    task automatic test_w1c_collision;
        logic [31:0] rd;
        bit          ok, ok2;
        pat0 = 8'hFF;
        wait_frame_end(ok);
        apb_read(A_STATE0, rd);
        checks++;
        if (!ok || rd !== 32'h0) begin failures++; $display("FAIL state0_released got=%h ok=%0d exp=0 1", rd, ok); end
        wait_frame_end(ok);
        pat0 = 8'h7E;
        wait_rise_latch(ok2);
        ok = ok && ok2;
        wait_clock_rises(8, ok2);
        ok = ok && ok2;
        repeat (2) @(negedge pclk);
        apb_write(A_PRESS0, 32'hFF);
        checks++;
        if (!ok) begin failures++; $display("FAIL collision_frame_timeout got=0 exp=1"); end
        apb_read(A_PRESS0, rd);
        checks++;
        if (rd !== 32'h81) begin failures++; $display("FAIL press0_set_wins got=%h exp=81", rd); end
        apb_read(A_STATE0, rd);
        checks++;
        if (rd !== 32'h81) begin failures++; $display("FAIL state0_collision got=%h exp=81", rd); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_collision got=%b exp=1", irq); end
    endtask

    task automatic test_en_abort;
        logic [31:0] rd;
        logic [31:0] f0;
        bit          ok, ok2;
        int          highs;
        wait_rise_latch(ok);
        apb_read(A_FRAMES, f0);
        wait_clock_rises(2, ok2);
        ok = ok && ok2;
        repeat (4) @(negedge pclk);
        apb_write(A_CTRL, 32'h2);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (pad_latch || pad_clock) highs++;
        end
        checks++;
        if (!ok || highs != 0) begin failures++; $display("FAIL abort_strobes got ok=%0d highs=%0d exp 1 0", ok, highs); end
        apb_read(A_FRAMES, rd);
        checks++;
        if (rd !== f0) begin failures++; $display("FAIL abort_frames got=%h exp=%h", rd, f0); end
        apb_read(A_STATE0, rd);
        checks++;
        if (rd !== 32'h81) begin failures++; $display("FAIL abort_state0 got=%h exp=81", rd); end
        pat0 = 8'hFE;
        pat1 = 8'h7F;
        apb_write(A_CTRL, 32'h3);
        wait_frame_end(ok);
        apb_read(A_STATE0, rd);
        checks++;
        if (!ok || rd !== 32'h80) begin failures++; $display("FAIL resume_state0 got=%h ok=%0d exp=80 1", rd, ok); end
        apb_read(A_STATE1, rd);
        checks++;
        if (rd !== 32'h01) begin failures++; $display("FAIL resume_state1 got=%h exp=1", rd); end
        apb_read(A_PRESS1, rd);
        checks++;
        if (rd !== 32'h01) begin failures++; $display("FAIL resume_press1 got=%h exp=1", rd); end
        apb_read(A_FRAMES, rd);
        checks++;
        if (rd !== f0 + 32'h1) begin failures++; $display("FAIL resume_frames got=%h exp=%h", rd, f0 + 32'h1); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] rd;
        bit          ok;
        int          highs;
        wait_clock_rises(1, ok);
        checks++;
        if (!ok || pad_clock !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got ok=%0d clk=%b irq=%b exp 1 1 1", ok, pad_clock, irq);
        end
        presetn = 1'b0;
        #1;
        checks++;
        if ({pad_latch, pad_clock, irq} !== 3'b000 || prdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got latch/clk/irq=%b prdata=%h exp=000 0", {pad_latch, pad_clock, irq}, prdata);
        end
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        apb_read(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_ctrl got=%h exp=0", rd); end
        apb_read(A_FRAMES, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_frames got=%h exp=0", rd); end
        apb_read(A_PRESS1, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_press1 got=%h exp=0", rd); end
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge pclk);
            if (pad_latch || pad_clock) highs++;
        end
        checks++;
        if (highs != 0) begin failures++; $display("FAIL post_reset_idle got highs=%0d exp=0", highs); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_second_frame();
        test_irq();
        test_w1c_collision();
        test_en_abort();
        test_reset_mid_frame();
        checks++;
        if (overlap !== 1'b0) begin failures++; $display("FAIL latch_clock_overlap got=%b exp=0", overlap); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
